// File: rtl/truth_table_sweep_if.sv
// Handshake and result bundle between the truth-table sweeper and whatever
// sits around it: vec drives the function under test and f returns from it.
interface truth_table_sweep_if #(
  parameter int N = 2
) ();
  logic              start;
  logic [N-1:0]      vec;
  logic              f;
  logic              busy;
  logic              done;
  logic              pass;
  logic [2**N-1:0]   tbl;
  logic [N-1:0]      err_idx;

  modport master (
    input  start, f,
    output vec, busy, done, pass, tbl, err_idx
  );

  modport slave (
    output start, f,
    input  vec, busy, done, pass, tbl, err_idx
  );
endinterface

// File: rtl/truth_table_sweep.sv
// Exhaustive truth-table sweeper: walks vec through 0..2^N-1, holds each value
// HOLD cycles, samples f on the last hold cycle and checks it against EXPECTED.
// The observed-table port is named tbl because "table" is a reserved word.
//
// state | meaning
// IDLE  | waiting for start, no results yet
// DRIVE | sweeping vectors, sampling f on the last hold cycle
// DONE  | results frozen until the next start
module truth_table_sweep #(
  parameter int              N        = 2,
  parameter int              HOLD     = 4,
  parameter logic [2**N-1:0] EXPECTED = 4'b0110
) (
  input  logic                   clk,
  input  logic                   reset,
  truth_table_sweep_if.master    bus
);

  localparam int             HW    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]  HLAST = HW'(HOLD - 1);
  localparam logic [N-1:0]   VLAST = {N{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t          state;
  logic [HW-1:0]   hcnt;
  logic [N-1:0]    vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [2**N-1:0] tbl;
  logic [N-1:0]    err_idx;

  assign bus.vec     = vec;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.pass    = pass;
  assign bus.tbl     = tbl;
  assign bus.err_idx = err_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hcnt    <= '0;
      vec     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      tbl     <= '0;
      err_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= DRIVE;
            hcnt    <= '0;
            vec     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b1;
            tbl     <= '0;
            err_idx <= '0;
          end
        end
        DRIVE: begin
          hcnt <= hcnt + 1'b1;
          if (hcnt == HLAST) begin
            tbl[vec] <= bus.f;
            // X/Z on f must count as a mismatch, hence the case inequality
            if ((bus.f !== EXPECTED[vec]) && pass) begin
              pass    <= 1'b0;
              err_idx <= vec;
            end
            if (vec == VLAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec  <= vec + 1'b1;
              hcnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep with N=2, HOLD=4, EXPECTED=0110; the
// function under test is selected by mode (xor, and, delayed xor, constant X).
module tb_truth_table_sweep;
  localparam int         N    = 2;
  localparam int         HOLD = 4;
  localparam logic [3:0] EXP  = 4'b0110;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;
  int   edges;
  logic d1, d2, d3, d4;

  always #5 clk = ~clk;

  truth_table_sweep_if #(.N(N)) bus ();

  truth_table_sweep #(.N(N), .HOLD(HOLD), .EXPECTED(EXP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // register chain models a function with internal pipeline delay
  always_ff @(posedge clk) begin
    d1 <= ^bus.vec;
    d2 <= d1;
    d3 <= d2;
    d4 <= d3;
  end

  always_comb begin
    bus.f = 1'bx;
    case (mode)
      0: bus.f = ^bus.vec;
      1: bus.f = &bus.vec;
      2: bus.f = d2;
      3: bus.f = d4;
      default: bus.f = 1'bx;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // start a sweep in mode m; optionally pulse start at edge pulse_at; count edges to done
  task automatic run_sweep(input int m, input int pulse_at, input bit track, output int n);
    mode = m;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_after_start", 32'(bus.done), 32'd0);
    check("vec_after_start", 32'(bus.vec), 32'd0);
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.start = (n == pulse_at);
      if (track && n < 16) check("vec_hold", 32'(bus.vec), 32'(n / 4));
    end
    bus.start = 1'b0;
    check("done_latency", 32'(n), 32'd16);
    check("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({bus.vec, bus.busy, bus.done, bus.pass, bus.tbl, bus.err_idx}), 32'd0);
    reset = 1'b0;

    run_sweep(0, 0, 1'b1, edges);
    check("xor_pass", 32'(bus.pass), 32'd1);
    check("xor_tbl", 32'(bus.tbl), 32'b0110);
    check("xor_err", 32'(bus.err_idx), 32'd0);
    check("xor_vec_last", 32'(bus.vec), 32'd3);
    repeat (3) @(negedge clk);
    check("done_frozen", 32'({bus.done, bus.pass, bus.tbl}), 32'b1_1_0110);

    // restart directly from DONE
    run_sweep(1, 0, 1'b0, edges);
    check("and_pass", 32'(bus.pass), 32'd0);
    check("and_tbl", 32'(bus.tbl), 32'b1000);
    check("and_err", 32'(bus.err_idx), 32'd1);

    run_sweep(2, 0, 1'b0, edges);
    check("dly2_pass", 32'(bus.pass), 32'd1);
    check("dly2_tbl", 32'(bus.tbl), 32'b0110);

    run_sweep(3, 0, 1'b0, edges);
    check("dly4_pass", 32'(bus.pass), 32'd0);
    check("dly4_err", 32'(bus.err_idx), 32'd1);
    check("dly4_tbl", 32'(bus.tbl), 32'b1100);

    run_sweep(0, 5, 1'b0, edges);
    check("pulse_pass", 32'(bus.pass), 32'd1);

    run_sweep(4, 0, 1'b0, edges);
    check("x_pass", 32'(bus.pass), 32'd0);

    // abort mid-sweep while vec==2
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("vec_before_abort", 32'(bus.vec), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 32'({bus.vec, bus.busy, bus.done, bus.pass, bus.tbl, bus.err_idx}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_sweep(0, 0, 1'b0, edges);
    check("post_abort_pass", 32'(bus.pass), 32'd1);
    check("post_abort_tbl", 32'(bus.tbl), 32'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
